program_sequencer: RTL and testbench

Single-clock fetch/issue controller between the instruction memory and the 4-register processor (mv/mvi/add/sub). It replaces the free-running address counter and the separate memory and processor clocks. It holds a program counter, reads synchronous memory, and drives the processor's DIN and Run. It waits for Done before fetching the next word, and supports a halt opcode, an illegal-opcode trap and a start/stop handshake.

---
 rtl/prog_seq_pkg.sv | 30 +++
 rtl/seq_pc_reg.sv | 33 +++
 rtl/program_sequencer.sv | 163 ++++++++++++++++
 tb/tb_program_sequencer.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_seq_pkg.sv
// Shared constants for the program sequencer: opcodes, instruction field
// positions and the controller state encoding.
package prog_seq_pkg;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam int OP_MSB = 6;
    localparam int OP_LSB = 4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_LATCH_I = 3'd2,
        S_LATCH_D = 3'd3,
        S_ISSUE   = 3'd4,
        S_EXEC    = 3'd5,
        S_HALTED  = 3'd6
    } state_t;

    // Opcodes 100..110 have no meaning to the processor and trap the sequencer.
    function automatic logic isLegal(input logic [2:0] op);
        return (op == OP_MV) || (op == OP_MVI) || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/seq_pc_reg.sv
// Program counter for the sequencer: reload to RESET_PC, +1 or +2 advance,
// and a PC+1 lookahead used to fetch the mvi immediate.
module seq_pc_reg #(
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_inc1,
    input  logic              i_inc2,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_pcPlus1
);

    logic [ADDR_W-1:0] r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= ADDR_W'(RESET_PC);
        end else if (i_load) begin
            r_pc <= ADDR_W'(RESET_PC);
        end else if (i_inc2) begin
            r_pc <= r_pc + ADDR_W'(2);
        end else if (i_inc1) begin
            r_pc <= r_pc + ADDR_W'(1);
        end
    end

    assign o_pc      = r_pc;
    assign o_pcPlus1 = r_pc + ADDR_W'(1);

endmodule

// File: rtl/program_sequencer.sv
// Fetch/issue controller between synchronous instruction memory and the
// 4-register processor. Define WATCHDOG_EN to trap instructions that never assert Done.
module program_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int RESET_PC = 0,
    parameter int WD_LIMIT = 7
) (
    input  logic              Clk,
    input  logic              Resetn,
    input  logic              Start,
    input  logic              Stop,
    input  logic              Done,
    input  logic [DATA_W-1:0] Mem_Data,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [DATA_W-1:0] DIN,
    output logic              Run,
    output logic [ADDR_W-1:0] PC,
    output logic              Busy,
    output logic              Halted,
    output logic              Error,
    output logic [7:0]        Instr_Count
);

    import prog_seq_pkg::*;

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_instr;
    logic [DATA_W-1:0] r_imm;
    logic              r_err;
    logic [7:0]        r_count;
    logic [ADDR_W-1:0] w_pcPlus1;
    logic [2:0]        w_fetchOp;
    logic              w_isMvi;
    logic              w_load;
    logic              w_retire;
    logic              w_setErr;

    assign w_fetchOp = Mem_Data[OP_MSB:OP_LSB];
    assign w_isMvi   = (r_instr[OP_MSB:OP_LSB] == OP_MVI);

    seq_pc_reg #(
        .ADDR_W  (ADDR_W),
        .RESET_PC(RESET_PC)
    ) u_pcReg (
        .clk      (Clk),
        .rst_n    (Resetn),
        .i_load   (w_load),
        .i_inc1   (w_retire & ~w_isMvi),
        .i_inc2   (w_retire & w_isMvi),
        .o_pc     (PC),
        .o_pcPlus1(w_pcPlus1)
    );

`ifdef WATCHDOG_EN
    logic [7:0] r_wdCnt;
    logic       w_wdExpired;

    assign w_wdExpired = (r_wdCnt == 8'(WD_LIMIT - 1));

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            r_wdCnt <= '0;
        end else if (r_state == S_ISSUE) begin
            r_wdCnt <= '0;
        end else if (r_state == S_EXEC && !Done) begin
            r_wdCnt <= r_wdCnt + 8'd1;
        end
    end
`else
    logic w_unusedWdLimit;
    assign w_unusedWdLimit = (WD_LIMIT != 0);
`endif

    // Decode is done straight off Mem_Data in LATCH_I so an mvi can already
    // present PC+1 to the memory in that same cycle.
    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_retire = 1'b0;
        w_setErr = 1'b0;
        Mem_Addr = PC;
        Run      = 1'b0;
        DIN      = '0;
        case (r_state)
            S_IDLE, S_HALTED: begin
                if (Start) begin
                    w_load = 1'b1;
                    w_next = S_FETCH;
                end
            end
            S_FETCH: w_next = S_LATCH_I;
            S_LATCH_I: begin
                if (w_fetchOp == OP_HALT) begin
                    w_next = S_HALTED;
                end else if (!isLegal(w_fetchOp)) begin
                    w_setErr = 1'b1;
                    w_next   = S_HALTED;
                end else if (w_fetchOp == OP_MVI) begin
                    Mem_Addr = w_pcPlus1;
                    w_next   = S_LATCH_D;
                end else begin
                    w_next = S_ISSUE;
                end
            end
            S_LATCH_D: w_next = S_ISSUE;
            S_ISSUE: begin
                Run    = 1'b1;
                DIN    = r_instr;
                w_next = S_EXEC;
            end
            S_EXEC: begin
                if (w_isMvi) begin
                    DIN = r_imm;
                end
                if (Done) begin
                    w_retire = 1'b1;
                    w_next   = Stop ? S_IDLE : S_FETCH;
                end
`ifdef WATCHDOG_EN
                else if (w_wdExpired) begin
                    w_setErr = 1'b1;
                    w_next   = S_HALTED;
                end
`endif
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= S_IDLE;
            r_instr <= '0;
            r_imm   <= '0;
            r_err   <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_LATCH_I) begin
                r_instr <= Mem_Data;
            end
            if (r_state == S_LATCH_D) begin
                r_imm <= Mem_Data;
            end
            if (w_load) begin
                r_err <= 1'b0;
            end else if (w_setErr) begin
                r_err <= 1'b1;
            end
            if (w_retire) begin
                r_count <= r_count + 8'd1;
            end
        end
    end

    assign Busy        = (r_state != S_IDLE) && (r_state != S_HALTED);
    assign Halted      = (r_state == S_HALTED);
    assign Error       = r_err;
    assign Instr_Count = r_count;

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: memory and processor models,
// an instruction-level schedule model compared every cycle, plus directed checks.
module tb_program_sequencer;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       done;
    logic       killDone = 1'b0;
    logic [7:0] memData = 8'h00;
    logic [7:0] memAddr;
    logic [7:0] din;
    logic       run;
    logic [7:0] pc;
    logic       busy;
    logic       halted;
    logic       error;
    logic [7:0] instrCount;

    int checks = 0;
    int failures = 0;
    int runCount = 0;
    bit checkEn = 1'b1;

    always #5 clk = ~clk;

    program_sequencer dut (
        .Clk        (clk),
        .Resetn     (resetn),
        .Start      (start),
        .Stop       (stop),
        .Done       (done),
        .Mem_Data   (memData),
        .Mem_Addr   (memAddr),
        .DIN        (din),
        .Run        (run),
        .PC         (pc),
        .Busy       (busy),
        .Halted     (halted),
        .Error      (error),
        .Instr_Count(instrCount)
    );

    logic [7:0] mem [256];

    always @(posedge clk) memData <= mem[memAddr];

    // Processor: T0 latches IR on Run; mv/mvi finish in T1, add/sub in T3.
    logic [7:0] rf [4];
    logic [7:0] pIr = 8'h00;
    logic [7:0] pA = 8'h00;
    logic [7:0] pG = 8'h00;
    int         pStep = 0;
    logic [2:0] pOp;
    logic       procDone;

    assign pOp      = pIr[6:4];
    assign procDone = (pStep == 1 && (pOp == 3'b000 || pOp == 3'b001)) || (pStep == 3);
    assign done     = procDone & ~killDone;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pStep <= 0;
            pIr   <= 8'h00;
            pA    <= 8'h00;
            pG    <= 8'h00;
            for (int i = 0; i < 4; i++) rf[i] <= 8'h00;
        end else begin
            case (pStep)
                0: if (run) begin pIr <= din; pStep <= 1; end
                1: begin
                    if (pOp == 3'b000) begin
                        rf[pIr[3:2]] <= rf[pIr[1:0]];
                        pStep <= 0;
                    end else if (pOp == 3'b001) begin
                        rf[pIr[3:2]] <= din;
                        pStep <= 0;
                    end else begin
                        pA <= rf[pIr[3:2]];
                        pStep <= 2;
                    end
                end
                2: begin
                    pG <= (pOp == 3'b010) ? pA + rf[pIr[1:0]] : pA - rf[pIr[1:0]];
                    pStep <= 3;
                end
                default: begin
                    rf[pIr[3:2]] <= pG;
                    pStep <= 0;
                end
            endcase
        end
    end

    always @(negedge clk) if (run) runCount++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each instruction expands into its list of bus cycles; the last
    // cycle carries what happens when it ends (retire, halt or trap).
    typedef struct {
        logic [7:0] addr;
        logic       run;
        logic [7:0] din;
        int         kind;
        int         inc;
    } cyc_t;

    localparam int K_NONE = 0, K_RETIRE = 1, K_HALT = 2, K_TRAP = 3;

    cyc_t       expQ[$];
    logic [7:0] mPc = 8'h00;
    logic [7:0] mCount = 8'h00;
    bit         mBusy = 1'b0;
    bit         mHalted = 1'b0;
    bit         mErr = 1'b0;

    task automatic pushCyc(input logic [7:0] a, input logic r, input logic [7:0] d,
                           input int k, input int inc);
        cyc_t c;
        c.addr = a; c.run = r; c.din = d; c.kind = k; c.inc = inc;
        expQ.push_back(c);
    endtask

    task automatic schedule(input logic [7:0] p);
        logic [7:0] w;
        logic [7:0] nx;
        logic [2:0] op;
        w  = mem[p];
        nx = p + 8'd1;
        op = w[6:4];
        pushCyc(p, 1'b0, 8'h00, K_NONE, 0);
        if (op == 3'b111) begin
            pushCyc(p, 1'b0, 8'h00, K_HALT, 0);
        end else if (op >= 3'b100) begin
            pushCyc(p, 1'b0, 8'h00, K_TRAP, 0);
        end else if (op == 3'b001) begin
            pushCyc(nx, 1'b0, 8'h00, K_NONE, 0);
            pushCyc(p, 1'b0, 8'h00, K_NONE, 0);
            pushCyc(p, 1'b1, w, K_NONE, 0);
            pushCyc(p, 1'b0, mem[nx], K_RETIRE, 2);
        end else begin
            pushCyc(p, 1'b0, 8'h00, K_NONE, 0);
            pushCyc(p, 1'b1, w, K_NONE, 0);
            if (op != 3'b000) begin
                pushCyc(p, 1'b0, 8'h00, K_NONE, 0);
                pushCyc(p, 1'b0, 8'h00, K_NONE, 0);
            end
            pushCyc(p, 1'b0, 8'h00, K_RETIRE, 1);
        end
    endtask

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            expQ.delete();
            mPc = 8'h00; mCount = 8'h00; mBusy = 1'b0; mHalted = 1'b0; mErr = 1'b0;
        end else if (!mBusy) begin
            if (start) begin
                mPc = 8'h00; mErr = 1'b0; mBusy = 1'b1; mHalted = 1'b0;
                schedule(mPc);
            end
        end else if (expQ.size() > 0) begin
            cyc_t c;
            c = expQ.pop_front();
            if (c.kind == K_RETIRE) begin
                mCount = mCount + 8'd1;
                mPc    = mPc + 8'(c.inc);
                if (stop) mBusy = 1'b0;
                else      schedule(mPc);
            end else if (c.kind == K_HALT || c.kind == K_TRAP) begin
                mBusy   = 1'b0;
                mHalted = 1'b1;
                if (c.kind == K_TRAP) mErr = 1'b1;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [7:0] eAddr;
        logic [7:0] eDin;
        logic       eRun;
        if (checkEn) begin
            eAddr = mPc; eDin = 8'h00; eRun = 1'b0;
            if (mBusy && expQ.size() > 0) begin
                eAddr = expQ[0].addr; eDin = expQ[0].din; eRun = expQ[0].run;
            end
            checkOutput("mem_addr", 32'(memAddr), 32'(eAddr));
            checkOutput("run", 32'(run), 32'(eRun));
            checkOutput("din", 32'(din), 32'(eDin));
            checkOutput("pc", 32'(pc), 32'(mPc));
            checkOutput("busy", 32'(busy), 32'(mBusy));
            checkOutput("halted", 32'(halted), 32'(mHalted));
            checkOutput("error", 32'(error), 32'(mErr));
            checkOutput("instr_count", 32'(instrCount), 32'(mCount));
        end
    end

    task automatic clearMem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h70;
    endtask

    // Holds Start/Stop for exactly one sampling edge; returns just after it.
    task automatic applyStimulus(input logic s, input logic p);
        @(posedge clk); #1;
        start = s; stop = p;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic waitNotBusy(input int limit);
        int n = 0;
        while (busy && n < limit) begin @(negedge clk); n++; end
        if (busy) checkOutput("timeout_busy", 32'(busy), 32'd0);
    endtask

    task automatic waitRunAt(input logic [7:0] target, input int limit);
        int n = 0;
        while (!(run && pc == target) && n < limit) begin @(negedge clk); n++; end
        if (!(run && pc == target)) checkOutput("timeout_run", 32'(run), 32'd1);
    endtask

    initial begin
        int busyCyc, runAt, doneAt, runsIn, runBefore, n;
        logic [7:0] a0, a1;

        for (int i = 0; i < 256; i++) mem[i] = 8'h70;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_pc", 32'(pc), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_count", 32'(instrCount), 32'd0);
        resetn = 1'b1;

        // Program: mvi R1,#5; mv R0,R1; add R0,R1; halt
        clearMem();
        mem[0] = 8'h14; mem[1] = 8'h05; mem[2] = 8'h01; mem[3] = 8'h21; mem[4] = 8'h70;
        runCount = 0;
        applyStimulus(1'b1, 1'b0);
        waitNotBusy(100);
        checkOutput("prog_r1", 32'(rf[1]), 32'd5);
        checkOutput("prog_r0", 32'(rf[0]), 32'd10);
        checkOutput("prog_halted", 32'(halted), 32'd1);
        checkOutput("prog_pc", 32'(pc), 32'd4);
        checkOutput("prog_count", 32'(instrCount), 32'd3);
        checkOutput("prog_error", 32'(error), 32'd0);
        checkOutput("prog_runs", 32'(runCount), 32'd3);

        // add timing: six cycles at PC 0, Run in cycle 3, Done in cycle 6
        clearMem();
        mem[0] = 8'h21;
        applyStimulus(1'b1, 1'b0);
        busyCyc = 0; runAt = -1; doneAt = -1; runsIn = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!(busy && pc == 8'd0)) break;
            busyCyc++;
            if (run) begin runAt = busyCyc; runsIn++; end
            if (done) doneAt = busyCyc;
        end
        checkOutput("add_cycles", 32'(busyCyc), 32'd6);
        checkOutput("add_run_cycle", 32'(runAt), 32'd3);
        checkOutput("add_run_pulses", 32'(runsIn), 32'd1);
        checkOutput("add_done_cycle", 32'(doneAt), 32'd6);
        waitNotBusy(20);

        // Illegal opcode traps without issuing; a new Start clears Error
        clearMem();
        mem[0] = 8'h40;
        runBefore = runCount;
        applyStimulus(1'b1, 1'b0);
        waitNotBusy(20);
        checkOutput("ill_error", 32'(error), 32'd1);
        checkOutput("ill_halted", 32'(halted), 32'd1);
        checkOutput("ill_pc", 32'(pc), 32'd0);
        checkOutput("ill_runs", 32'(runCount - runBefore), 32'd0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("ill_err_cleared", 32'(error), 32'd0);
        waitNotBusy(20);

        // mvi at PC 255 takes its immediate from address 0 and wraps PC to 1
        clearMem();
        mem[0] = 8'h2A;
        for (int i = 1; i < 255; i++) mem[i] = 8'h00;
        mem[255] = 8'h18;
        applyStimulus(1'b1, 1'b0);
        n = 0;
        while (pc != 8'd255 && n < 3000) begin @(negedge clk); n++; end
        checkOutput("wrap_reached", 32'(pc), 32'd255);
        stop = 1'b1;
        a0 = memAddr;
        @(negedge clk);
        a1 = memAddr;
        checkOutput("wrap_addr0", 32'(a0), 32'd255);
        checkOutput("wrap_addr1", 32'(a1), 32'd0);
        waitNotBusy(20);
        stop = 1'b0;
        checkOutput("wrap_pc", 32'(pc), 32'd1);
        checkOutput("wrap_r2", 32'(rf[2]), 32'h2A);
        checkOutput("wrap_idle", 32'(halted), 32'd0);

        // Stop during EXEC retires the add then idles; Start+Stop together runs
        clearMem();
        mem[0] = 8'h21;
        applyStimulus(1'b1, 1'b0);
        waitRunAt(8'd0, 20);
        @(posedge clk); #1;
        stop = 1'b1;
        waitNotBusy(20);
        stop = 1'b0;
        checkOutput("stop_busy", 32'(busy), 32'd0);
        checkOutput("stop_halted", 32'(halted), 32'd0);
        checkOutput("stop_pc", 32'(pc), 32'd1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("startstop_busy", 32'(busy), 32'd1);
        waitNotBusy(30);
        checkOutput("startstop_halted", 32'(halted), 32'd1);

        // Reset in the middle of an add's EXEC
        clearMem();
        mem[0] = 8'h00; mem[1] = 8'h21;
        applyStimulus(1'b1, 1'b0);
        waitRunAt(8'd1, 30);
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        checkOutput("arst_pc", 32'(pc), 32'd0);
        checkOutput("arst_addr", 32'(memAddr), 32'd0);
        checkOutput("arst_busy", 32'(busy), 32'd0);
        checkOutput("arst_run", 32'(run), 32'd0);
        checkOutput("arst_din", 32'(din), 32'd0);
        checkOutput("arst_count", 32'(instrCount), 32'd0);
        checkOutput("arst_error", 32'(error), 32'd0);
        checkOutput("arst_halted", 32'(halted), 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

`ifdef WATCHDOG_EN
        // Done suppressed: trap after WD_LIMIT EXEC cycles with no retire
        checkEn = 1'b0;
        killDone = 1'b1;
        clearMem();
        mem[0] = 8'h21;
        applyStimulus(1'b1, 1'b0);
        waitRunAt(8'd0, 20);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (halted) break;
            n++;
        end
        checkOutput("wd_exec_cycles", 32'(n), 32'd7);
        checkOutput("wd_error", 32'(error), 32'd1);
        checkOutput("wd_pc", 32'(pc), 32'd0);
        checkOutput("wd_count", 32'(instrCount), 32'd0);
        killDone = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] simulation time limit");
    end

endmodule
